// File: rtl/core_flit_injector_pkg.sv
// Shared definitions for the core-side flit injector.
// Contents: flit type encodings, FSM state enum, head-field bit offsets.
// The head flit layout below the 2-bit type is {vc, flow, len, zero pad},
// packed from the MSB downward.
package core_flit_injector_pkg;

  localparam int TYPE_W = 2;

  localparam logic [TYPE_W-1:0] FLIT_HEAD = 2'b01;
  localparam logic [TYPE_W-1:0] FLIT_BODY = 2'b00;
  localparam logic [TYPE_W-1:0] FLIT_TAIL = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } inj_state_e;

  // LSB positions of the head fields for a given flit/field geometry.
  function automatic int head_vc_lsb(input int dw, input int vcb);
    return dw - TYPE_W - vcb;
  endfunction

  function automatic int head_flow_lsb(input int dw, input int vcb, input int fb);
    return dw - TYPE_W - vcb - fb;
  endfunction

  function automatic int head_len_lsb(input int dw, input int vcb, input int fb,
                                      input int lb);
    return dw - TYPE_W - vcb - fb - lb;
  endfunction

endpackage

// File: rtl/core_flit_injector_hold.sv
// flit_hold_reg: single-entry output register between the packetizer and
// the router wrapper's core input port.
// Ports:
//   clk, reset      - clock, async active-low reset
//   on              - global enable; no transfer while low
//   vc_full         - per-VC full flags from the wrapper
//   load/load_flit/load_vc - new flit to capture (caller only loads when free)
//   flit_out/flit_valid    - to the wrapper
//   xfer            - flit handed to the wrapper this cycle
//   free            - register may accept a new flit this cycle
module flit_hold_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int VC_BITS    = 1,
  parameter int NUM_VCS    = 1 << VC_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  on,
  input  logic [NUM_VCS-1:0]    vc_full,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_flit,
  input  logic [VC_BITS-1:0]    load_vc,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  output logic                  xfer,
  output logic                  free
);

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_flit;
  logic [VC_BITS-1:0]    hold_vc;

  // Full flag is checked combinationally, so a flit only leaves when the
  // wrapper can take it; nothing is ever in flight toward a full FIFO.
  assign xfer       = hold_valid && !vc_full[hold_vc] && on;
  assign free       = !hold_valid || xfer;
  assign flit_valid = xfer;
  assign flit_out   = hold_flit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_flit  <= '0;
      hold_vc    <= '0;
    end else if (load) begin
      // Load wins over xfer: same-cycle replace, no bubble.
      hold_valid <= 1'b1;
      hold_flit  <= load_flit;
      hold_vc    <= load_vc;
    end else if (xfer) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/core_flit_injector.sv
// core_flit_injector: turns a core word stream into head/body/tail flits for
// the router wrapper's core input port, gated by per-VC full flags.
// Ports:
//   clk, reset                 - clock, async active-low reset
//   ON                         - enable; freezes the block when low
//   msg_flow/msg_vc/msg_len    - packet header info, sampled at head load
//   word_data/valid/last/ready - payload word handshake
//   flit_out/flit_valid        - to core_data_in/core_valid_in
//   vc_full                    - from core_full_out
//   pkt_count/flit_count       - wrapping tail-flit and flit transfer counts
module core_flit_injector
  import core_flit_injector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FLOW_BITS  = 8,
  parameter int VC_BITS    = 1,
  parameter int LEN_BITS   = 8,
  parameter int CNT_BITS   = 16,
  parameter int NUM_VCS    = 1 << VC_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ON,
  input  logic [FLOW_BITS-1:0]     msg_flow,
  input  logic [VC_BITS-1:0]       msg_vc,
  input  logic [LEN_BITS-1:0]      msg_len,
  input  logic [DATA_WIDTH-3:0]    word_data,
  input  logic                     word_valid,
  input  logic                     word_last,
  output logic                     word_ready,
  output logic [DATA_WIDTH-1:0]    flit_out,
  output logic                     flit_valid,
  input  logic [NUM_VCS-1:0]       vc_full,
  output logic [CNT_BITS-1:0]      pkt_count,
  output logic [CNT_BITS-1:0]      flit_count
);

  localparam int VC_LSB   = head_vc_lsb(DATA_WIDTH, VC_BITS);
  localparam int FLOW_LSB = head_flow_lsb(DATA_WIDTH, VC_BITS, FLOW_BITS);
  localparam int LEN_LSB  = head_len_lsb(DATA_WIDTH, VC_BITS, FLOW_BITS, LEN_BITS);
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  inj_state_e            state, next_state;
  logic [VC_BITS-1:0]    lat_vc;
  logic                  free, xfer, load;
  logic [DATA_WIDTH-1:0] load_flit, head_flit;
  logic [VC_BITS-1:0]    load_vc;

  // Head flit: {type, vc, flow, len, zero pad}. The flow ID only lives in
  // the head, so the hold register is where it is effectively latched.
  always_comb begin
    head_flit = '0;
    head_flit[DATA_WIDTH-1 -: TYPE_W]  = FLIT_HEAD;
    head_flit[VC_LSB   +: VC_BITS]     = msg_vc;
    head_flit[FLOW_LSB +: FLOW_BITS]   = msg_flow;
    head_flit[LEN_LSB  +: LEN_BITS]    = msg_len;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic. The head is loaded on word_valid but the word itself
  // stays on the bus and is consumed in BODY.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (word_valid && free && ON)               next_state = ST_BODY;
      ST_BODY: if (word_valid && word_ready && word_last)  next_state = ST_IDLE;
      default:                                             next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    word_ready = 1'b0;
    load       = 1'b0;
    load_flit  = head_flit;
    load_vc    = msg_vc;
    case (state)
      ST_IDLE: begin
        load = word_valid && free && ON;
      end
      ST_BODY: begin
        word_ready = free && ON;
        load       = word_valid && free && ON;
        load_flit  = {(word_last ? FLIT_TAIL : FLIT_BODY), word_data};
        load_vc    = lat_vc;
      end
      default: ;
    endcase
  end

  // Body/tail flits follow the VC chosen at head time, whatever msg_vc does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       lat_vc <= '0;
    else if (state == ST_IDLE && load) lat_vc <= msg_vc;
  end

  flit_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .VC_BITS    (VC_BITS),
    .NUM_VCS    (NUM_VCS)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .on         (ON),
    .vc_full    (vc_full),
    .load       (load),
    .load_flit  (load_flit),
    .load_vc    (load_vc),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .xfer       (xfer),
    .free       (free)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_count <= '0;
      pkt_count  <= '0;
    end else if (xfer) begin
      flit_count <= flit_count + CNT_ONE;
      if (flit_out[DATA_WIDTH-1 -: TYPE_W] == FLIT_TAIL)
        pkt_count <= pkt_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_core_flit_injector.sv
// Directed bench for core_flit_injector: inputs change on the falling edge,
// outputs are checked 1 ns later, expected values are hand-built constants.
module tb_core_flit_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic        ON;
  logic [7:0]  msg_flow;
  logic [0:0]  msg_vc;
  logic [7:0]  msg_len;
  logic [29:0] word_data;
  logic        word_valid, word_last, word_ready;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic [1:0]  vc_full;
  logic [15:0] pkt_count, flit_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_flit_injector dut (
    .clk        (clk),
    .reset      (reset),
    .ON         (ON),
    .msg_flow   (msg_flow),
    .msg_vc     (msg_vc),
    .msg_len    (msg_len),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .vc_full    (vc_full),
    .pkt_count  (pkt_count),
    .flit_count (flit_count)
  );

  function automatic logic [31:0] hd(input logic vc, input logic [7:0] fl, input logic [7:0] ln);
    return {2'b01, vc, fl, ln, 13'h0};
  endfunction
  function automatic logic [31:0] bd(input logic [29:0] d);
    return {2'b00, d};
  endfunction
  function automatic logic [31:0] tl(input logic [29:0] d);
    return {2'b10, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic fv, input logic wr, input logic [31:0] fo);
    chk({tag, ".flit_valid"}, {31'b0, flit_valid}, {31'b0, fv});
    chk({tag, ".word_ready"}, {31'b0, word_ready}, {31'b0, wr});
    chk({tag, ".flit_out"},   flit_out, fo);
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] pk, input logic [15:0] fc);
    chk({tag, ".pkt_count"},  {16'b0, pkt_count},  {16'b0, pk});
    chk({tag, ".flit_count"}, {16'b0, flit_count}, {16'b0, fc});
  endtask

  task automatic set_msg(input logic vc, input logic [7:0] fl, input logic [7:0] ln);
    msg_vc = vc; msg_flow = fl; msg_len = ln;
  endtask

  initial begin
    reset = 1'b0; ON = 1'b1; vc_full = 2'b00;
    set_msg(1'b0, 8'h00, 8'h00);
    word_data = '0; word_valid = 1'b0; word_last = 1'b0;
    #1;
    chk_out("reset", 1'b0, 1'b0, 32'h0);
    chk_cnt("reset", 16'd0, 16'd0);
    @(negedge clk); reset = 1'b1;

    // Single-word packet on VC1
    @(negedge clk);
    set_msg(1'b1, 8'h2A, 8'h01);
    word_valid = 1'b1; word_data = 30'h1234; word_last = 1'b1;
    #1 chk_out("s1_idle", 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1 chk_out("s1_head", 1'b1, 1'b1, hd(1'b1, 8'h2A, 8'h01));
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    #1 chk_out("s1_tail", 1'b1, 1'b0, tl(30'h1234));
    @(negedge clk); #1 chk_out("s1_done", 1'b0, 1'b0, tl(30'h1234));
    chk_cnt("s1", 16'd1, 16'd2);

    // 4-word packet, VC0, no backpressure: five flits back to back
    @(negedge clk);
    set_msg(1'b0, 8'h05, 8'h04);
    word_valid = 1'b1; word_data = 30'hA0; word_last = 1'b0;
    #1 chk("s2_idle.flit_valid", {31'b0, flit_valid}, 32'h0);
    @(negedge clk); #1 chk_out("s2_head", 1'b1, 1'b1, hd(1'b0, 8'h05, 8'h04));
    @(negedge clk); word_data = 30'hA1; #1 chk_out("s2_b0", 1'b1, 1'b1, bd(30'hA0));
    @(negedge clk); word_data = 30'hA2; #1 chk_out("s2_b1", 1'b1, 1'b1, bd(30'hA1));
    @(negedge clk); word_data = 30'hA3; word_last = 1'b1;
    #1 chk_out("s2_b2", 1'b1, 1'b1, bd(30'hA2));
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    #1 chk_out("s2_tail", 1'b1, 1'b0, tl(30'hA3));
    @(negedge clk); #1 chk("s2_done.flit_valid", {31'b0, flit_valid}, 32'h0);
    chk_cnt("s2", 16'd2, 16'd7);

    // Backpressure on VC1 for 3 cycles; msg_vc flips meanwhile and must be ignored
    @(negedge clk);
    set_msg(1'b1, 8'h11, 8'h03);
    word_valid = 1'b1; word_data = 30'hB0; word_last = 1'b0;
    #1 chk("s3_idle.flit_valid", {31'b0, flit_valid}, 32'h0);
    @(negedge clk); #1 chk_out("s3_head", 1'b1, 1'b1, hd(1'b1, 8'h11, 8'h03));
    @(negedge clk); word_data = 30'hB1; vc_full = 2'b10; msg_vc = 1'b0;
    #1 chk_out("s3_stall0", 1'b0, 1'b0, bd(30'hB0));
    @(negedge clk); #1 chk_out("s3_stall1", 1'b0, 1'b0, bd(30'hB0));
    @(negedge clk); #1 chk_out("s3_stall2", 1'b0, 1'b0, bd(30'hB0));
    // Only VC0 full now: VC1 packet must keep flowing on its latched VC
    @(negedge clk); vc_full = 2'b01;
    #1 chk_out("s3_rel", 1'b1, 1'b1, bd(30'hB0));
    @(negedge clk); word_data = 30'hB2; word_last = 1'b1;
    #1 chk_out("s3_b1", 1'b1, 1'b1, bd(30'hB1));
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    #1 chk_out("s3_tail", 1'b1, 1'b0, tl(30'hB2));
    @(negedge clk); vc_full = 2'b00; msg_vc = 1'b1;
    #1 chk("s3_done.flit_valid", {31'b0, flit_valid}, 32'h0);
    chk_cnt("s3", 16'd3, 16'd11);

    // Back-to-back: VC0 packet then VC1 packet, head follows tail directly
    @(negedge clk);
    set_msg(1'b0, 8'h01, 8'h01);
    word_valid = 1'b1; word_data = 30'hC0; word_last = 1'b1;
    #1 chk("s4_idle.flit_valid", {31'b0, flit_valid}, 32'h0);
    @(negedge clk); #1 chk_out("s4_headA", 1'b1, 1'b1, hd(1'b0, 8'h01, 8'h01));
    @(negedge clk); set_msg(1'b1, 8'h02, 8'h01); word_data = 30'hD0;
    #1 chk_out("s4_tailA", 1'b1, 1'b0, tl(30'hC0));
    @(negedge clk); vc_full = 2'b01;
    #1 chk_out("s4_headB", 1'b1, 1'b1, hd(1'b1, 8'h02, 8'h01));
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    #1 chk_out("s4_tailB", 1'b1, 1'b0, tl(30'hD0));
    @(negedge clk); vc_full = 2'b00;
    #1 chk("s4_done.flit_valid", {31'b0, flit_valid}, 32'h0);
    chk_cnt("s4", 16'd5, 16'd15);

    // ON low freezes the packet, then async reset mid-BODY
    @(negedge clk);
    set_msg(1'b0, 8'h03, 8'h02);
    word_valid = 1'b1; word_data = 30'hE0; word_last = 1'b0;
    #1 chk("s5_idle.flit_valid", {31'b0, flit_valid}, 32'h0);
    @(negedge clk); ON = 1'b0;
    #1 chk_out("s5_off", 1'b0, 1'b0, hd(1'b0, 8'h03, 8'h02));
    @(negedge clk); ON = 1'b1;
    #1 chk_out("s5_head", 1'b1, 1'b1, hd(1'b0, 8'h03, 8'h02));
    @(negedge clk); word_data = 30'hE1;
    #1 chk_out("s5_b0", 1'b1, 1'b1, bd(30'hE0));
    #2 reset = 1'b0;
    #1 chk_out("s5_rst", 1'b0, 1'b0, 32'h0);
    chk_cnt("s5_rst", 16'd0, 16'd0);
    @(negedge clk); reset = 1'b1;
    set_msg(1'b0, 8'h04, 8'h01); word_data = 30'hF0; word_last = 1'b1;
    #1 chk_out("s5_post", 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1 chk_out("s5_head2", 1'b1, 1'b1, hd(1'b0, 8'h04, 8'h01));
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    #1 chk_out("s5_tail2", 1'b1, 1'b0, tl(30'hF0));
    @(negedge clk); #1 chk_cnt("s5", 16'd1, 16'd2);

    // Counter wrap: one packet of 65535 words = 65536 flits from zero
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    set_msg(1'b0, 8'h07, 8'hFF);
    word_valid = 1'b1; word_data = '0; word_last = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      word_data = 30'(i);
      word_last = (i == 65534);
    end
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    #1 chk_out("s6_tail", 1'b1, 1'b0, tl(30'hFFFE));
    chk_cnt("s6_pre", 16'd0, 16'hFFFF);
    @(negedge clk); #1 chk_cnt("s6_wrap", 16'd1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
